// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// stopwatch_pkg : state encoding and default divisors for stopwatch_ctrl
// Rev 1.0
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_PAUSE  = 2'd1,
    ST_ADJUST = 2'd2
  } state_e;

  localparam int unsigned DEF_ONE_HZ_DIV = 100_000_000;
  localparam int unsigned DEF_TWO_HZ_DIV = 50_000_000;
  localparam int unsigned DEF_BLINK_DIV  = 25_000_000;

endpackage
`default_nettype wire

// File: rtl/clk_en_div.sv
`default_nettype none
// ============================================================================
// clk_en_div : modulo-DIV counter emitting a registered one-cycle tc_pulse
// Rev 1.0
// ============================================================================
module clk_en_div #(
  parameter int unsigned DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tc_pulse
);

  localparam int unsigned   W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q;
  logic         tc_q;

  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else if (run) begin
      if (cnt_q == LAST) begin
        cnt_q <= '0;
        tc_q  <= 1'b1;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        tc_q  <= 1'b0;
      end
    end else begin
      tc_q <= 1'b0;
    end
  end

  assign tc_pulse = tc_q;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// stopwatch_ctrl : RUN/PAUSE/ADJUST control with 1 Hz, 2 Hz and blink dividers
// Rev 1.0
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned ONE_HZ_DIV = DEF_ONE_HZ_DIV,
  parameter int unsigned TWO_HZ_DIV = DEF_TWO_HZ_DIV,
  parameter int unsigned BLINK_DIV  = DEF_BLINK_DIV
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       pause_btn,
  input  logic       adj,
  input  logic       sel,
  output logic       count_en,
  output logic       inc_sec,
  output logic       inc_min,
  output logic       blink_on,
  output logic [1:0] state
);

  state_e state_q;
  logic   run_saved_q;
  logic   pause_q;
  logic   sel_q;
  logic   blink_q;
  logic   pause_edge;
  logic   in_run;
  logic   in_adj;
  logic   tc_1hz;
  logic   tc_2hz;
  logic   tc_blink;

  assign pause_edge = pause_btn & ~pause_q;
  assign in_run     = (state_q == ST_RUN);
  assign in_adj     = (state_q == ST_ADJUST);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_RUN;
      run_saved_q <= 1'b1;
      pause_q     <= 1'b1;
      sel_q       <= 1'b0;
    end else begin
      pause_q <= pause_btn;
      sel_q   <= sel;
      case (state_q)
        ST_RUN: begin
          if (adj) begin
            state_q     <= ST_ADJUST;
            run_saved_q <= ~pause_edge;
          end else if (pause_edge) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (adj) begin
            state_q     <= ST_ADJUST;
            run_saved_q <= pause_edge;
          end else if (pause_edge) begin
            state_q <= ST_RUN;
          end
        end
        ST_ADJUST: begin
          // a pause edge on the exit cycle still toggles the resume target
          run_saved_q <= run_saved_q ^ pause_edge;
          if (!adj) begin
            state_q <= (run_saved_q ^ pause_edge) ? ST_RUN : ST_PAUSE;
          end
        end
        default: state_q <= ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset || !in_adj) begin
      blink_q <= 1'b1;
    end else begin
      blink_q <= blink_q ^ tc_blink;
    end
  end

  clk_en_div #(.DIV(ONE_HZ_DIV)) u_div_1hz (
    .clock    (clock),
    .reset    (reset),
    .clr      (1'b0),
    .run      (in_run),
    .tc_pulse (tc_1hz)
  );

  clk_en_div #(.DIV(TWO_HZ_DIV)) u_div_2hz (
    .clock    (clock),
    .reset    (reset),
    .clr      (~in_adj),
    .run      (in_adj),
    .tc_pulse (tc_2hz)
  );

  clk_en_div #(.DIV(BLINK_DIV)) u_div_blink (
    .clock    (clock),
    .reset    (reset),
    .clr      (~in_adj),
    .run      (in_adj),
    .tc_pulse (tc_blink)
  );

  // the blink terminal pulse is folded in so the toggle lands on the wrap cycle
  assign count_en = tc_1hz;
  assign inc_sec  = tc_2hz & ~sel_q;
  assign inc_min  = tc_2hz & sel_q;
  assign blink_on = ~in_adj | (blink_q ^ tc_blink);
  assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_stopwatch_ctrl : directed + random stimulus against a behavioural model
// Rev 1.0
// ============================================================================
module tb_stopwatch_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pause_btn = 1'b0;
  logic       adj = 1'b0;
  logic       sel = 1'b0;
  logic       count_en, inc_sec, inc_min, blink_on;
  logic [1:0] state;

  always #5 clock = ~clock;

  stopwatch_ctrl #(
    .ONE_HZ_DIV (8),
    .TWO_HZ_DIV (4),
    .BLINK_DIV  (2)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .pause_btn (pause_btn),
    .adj       (adj),
    .sel       (sel),
    .count_en  (count_en),
    .inc_sec   (inc_sec),
    .inc_min   (inc_min),
    .blink_on  (blink_on),
    .state     (state)
  );

  int total = 0;
  int bad   = 0;

  // model: mode 0=RUN 1=PAUSE 2=ADJUST; time is counted in elapsed edges
  int m_mode      = 0;
  bit m_run_saved = 1'b1;
  bit m_btn_prev  = 1'b1;
  int run_ticks   = 0;
  int adj_ticks   = 0;
  bit e_ce, e_is, e_im, e_bl;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit pe;
    pe = pause_btn && !m_btn_prev;
    e_ce = 1'b0;
    e_is = 1'b0;
    e_im = 1'b0;
    if (reset) begin
      m_mode      = 0;
      m_run_saved = 1'b1;
      m_btn_prev  = 1'b1;
      run_ticks   = 0;
      adj_ticks   = 0;
    end else begin
      if (m_mode == 0) begin
        run_ticks++;
        e_ce = (run_ticks % 8 == 0);
      end
      if (m_mode == 2) begin
        adj_ticks++;
        e_is = (adj_ticks % 4 == 0) && !sel;
        e_im = (adj_ticks % 4 == 0) && sel;
      end else begin
        adj_ticks = 0;
      end
      case (m_mode)
        0: if (adj) begin m_mode = 2; m_run_saved = !pe; end
           else if (pe) m_mode = 1;
        1: if (adj) begin m_mode = 2; m_run_saved = pe; end
           else if (pe) m_mode = 0;
        default: begin
          if (pe) m_run_saved = !m_run_saved;
          if (!adj) m_mode = m_run_saved ? 0 : 1;
        end
      endcase
      m_btn_prev = pause_btn;
    end
    e_bl = (m_mode != 2) ? 1'b1 : (((adj_ticks / 2) % 2) == 0);
  endtask

  task automatic cyc(input logic r, input logic pb, input logic a, input logic s);
    @(negedge clock);
    reset = r; pause_btn = pb; adj = a; sel = s;
    @(posedge clock);
    model_edge();
    #1;
    check_val("count_en", 32'(count_en), 32'(e_ce));
    check_val("inc_sec",  32'(inc_sec),  32'(e_is));
    check_val("inc_min",  32'(inc_min),  32'(e_im));
    check_val("blink_on", 32'(blink_on), 32'(e_bl));
    check_val("state",    32'(state),    32'(m_mode));
  endtask

  initial begin
    int n;
    logic pb, a, s;

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);

    n = 0;
    for (int i = 1; i <= 24; i++) begin
      cyc(0, 0, 0, 0);
      n += int'(count_en);
    end
    check_val("ce_pulses_24", 32'(n), 32'd3);

    cyc(1, 0, 0, 0);
    for (int i = 1; i <= 30; i++) cyc(0, (i == 5 || i == 20), 0, 0);

    cyc(1, 0, 0, 0);
    for (int i = 0; i <= 12; i++) cyc(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);

    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0);
    check_val("held_btn_run", 32'(state), 32'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 1, 0, 0);
    check_val("repress_pause", 32'(state), 32'd1);

    cyc(0, 0, 0, 0);
    cyc(0, 1, 1, 0);
    check_val("pause_adj_enter", 32'(state), 32'd2);
    cyc(0, 0, 0, 0);
    check_val("adj_exit_run", 32'(state), 32'd0);

    cyc(1, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    check_val("reset_at_tc", 32'(count_en), 32'd0);
    cyc(0, 0, 0, 0);

    pb = 1'b0; a = 1'b0; s = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(5, 0) == 0)  pb = ~pb;
      if ($urandom_range(19, 0) == 0) a  = ~a;
      if ($urandom_range(3, 0) == 0)  s  = ~s;
      cyc(($urandom_range(499, 0) == 0), pb, a, s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter ONE_HZ_DIV, default 100_000_000, clock cycles per count_en pulse.
REQ-002 Parameter TWO_HZ_DIV, default 50_000_000, clock cycles per inc_sec/inc_min pulse.
REQ-003 Parameter BLINK_DIV, default 25_000_000, clock cycles per blink_on toggle in ADJUST.
REQ-004 clock  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pause_btn  input  1  debounced, synchronized level; a rising edge is one pause command.
REQ-007 adj  input  1  level; 1 selects adjust mode.
REQ-008 sel  input  1  adjust target; 0 = seconds, 1 = minutes.
REQ-009 count_en  output  1  one-cycle pulse; advances the mm:ss counter by one second.
REQ-010 inc_sec  output  1  one-cycle pulse; increments the seconds field in adjust mode.
REQ-011 inc_min  output  1  one-cycle pulse; increments the minutes field in adjust mode.
REQ-012 blink_on  output  1  display enable for the selected field; 1 = digits lit.
REQ-013 state  output  2  current FSM state (RUN=0, PAUSE=1, ADJUST=2).

Function
REQ-014 FSM states SHALL be RUN, PAUSE and ADJUST; encoding 3 SHALL be unreachable and SHALL recover to RUN on the next edge.
REQ-015 A pause edge SHALL be defined as pause_btn=1 with registered pause_q=0, evaluated at a clock edge.
REQ-016 RUN on pause edge -> PAUSE; PAUSE on pause edge -> RUN, taking effect on the same clock edge.
REQ-017 RUN or PAUSE with adj=1 -> ADJUST; the pre-entry state SHALL be saved in flag run_saved (1 = RUN).
REQ-018 ADJUST with adj=0 -> RUN if run_saved=1, else PAUSE.
REQ-019 A pause edge in ADJUST SHALL toggle run_saved and leave the state in ADJUST.
REQ-020 adj=1 and a pause edge in the same cycle from RUN/PAUSE: enter ADJUST, and store the toggled value as run_saved.
REQ-021 The 1 Hz divider SHALL count only in RUN and hold its value in PAUSE/ADJUST, so a resume continues the partial second.
REQ-022 When the 1 Hz divider reaches ONE_HZ_DIV-1 in RUN it SHALL wrap to 0 and register count_en=1 for exactly the next cycle.
REQ-023 A terminal count coinciding with a RUN->PAUSE/ADJUST transition SHALL still emit that count_en pulse.
REQ-024 The 2 Hz divider SHALL clear on ADJUST entry and count only in ADJUST; at TWO_HZ_DIV-1 it wraps and registers one pulse on inc_sec (sel=0) or inc_min (sel=1), using the sel sampled at that edge.
REQ-025 count_en, inc_sec and inc_min SHALL be mutually exclusive and registered (no combinational path from inputs).
REQ-026 blink_on SHALL be 1 outside ADJUST. In ADJUST it SHALL toggle every BLINK_DIV cycles, starting at 1 on entry.

Reset
REQ-027 On reset: state=RUN, run_saved=1, all dividers=0, count_en=inc_sec=inc_min=0, blink_on=1.
REQ-028 pause_q SHALL reset to 1, so a button held through reset generates no pause edge.
REQ-029 Reset asserted mid-operation SHALL override all other inputs on that edge, including any pending terminal count.

Structure
REQ-030 Package stopwatch_pkg SHALL hold the state encoding constants and the default divisor values.
REQ-031 Sub-module clk_en_div SHALL provide a parameterized divider with ports clock, reset, clr, run and tc_pulse; it is instantiated three times (1 Hz, 2 Hz, blink).
REQ-032 Divider width SHALL be $clog2 of its divisor; no divider SHALL overflow at its terminal count.

Verification (ONE_HZ_DIV=8, TWO_HZ_DIV=4, BLINK_DIV=2)
REQ-033 Release reset, idle 24 cycles -> count_en pulses at cycles 8, 16 and 24, one cycle wide; state=0.
REQ-034 Pause edge at cycle 5, resume edge at cycle 20 -> no pulse during PAUSE; next count_en at cycle 23 (partial count of 5 retained).
REQ-035 adj=1, sel=1 for 12 cycles -> inc_min at cycles 4, 8 and 12; inc_sec=0; blink_on toggles every 2 cycles; adj=0 -> returns to RUN.
REQ-036 Hold pause_btn=1 through reset and for 10 cycles after -> no state change; a release then re-press toggles to PAUSE.
REQ-037 From PAUSE, adj=1 and a pause edge in the same cycle, then adj=0 -> state goes ADJUST, then RUN.
REQ-038 Reset at the cycle the 1 Hz divider is at 7 -> no count_en; all outputs at reset values on the next cycle.
